// File: rtl/ubus_arbiter_n_if.sv
// ubus_arbiter_n_if: bundles the UBUS arbitration and bus-phase signals.
// The "master" modport is the arbiter's view (it owns grants and phase
// strobes); the "slave" modport is the view of the requesting agents and
// slaves, which drive requests, burst, wait and error.
interface ubus_arbiter_n_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 4
);
    logic [NUM_MASTERS-1:0] ubus_req;
    logic [NUM_MASTERS-1:0] ubus_gnt;
    logic [ID_W-1:0]        ubus_gnt_id;
    logic                   ubus_start;
    logic                   ubus_bip;
    logic                   ubus_wait;
    logic                   ubus_error;
    logic                   ubus_read;
    logic                   ubus_write;
    logic                   ubus_rw_oe;
    logic                   arb_timeout;

    modport master (
        input  ubus_req, ubus_bip, ubus_wait, ubus_error,
        output ubus_gnt, ubus_gnt_id, ubus_start,
        output ubus_read, ubus_write, ubus_rw_oe, arb_timeout
    );

    modport slave (
        output ubus_req, ubus_bip, ubus_wait, ubus_error,
        input  ubus_gnt, ubus_gnt_id, ubus_start,
        input  ubus_read, ubus_write, ubus_rw_oe, arb_timeout
    );
endinterface

// File: rtl/ubus_arbiter_n.sv
// ubus_arbiter_n: UBUS bus-phase controller and N-master arbiter.
// Walks RESET -> START -> ADDR -> DATA (or START -> NOOP) and issues a
// single-cycle one-hot grant aligned with ADDR. Arbitration is fixed
// priority (ARB_MODE=0, index 0 highest) or round-robin (ARB_MODE=1).
// Optional DATA-phase watchdog enabled by defining UBUS_ARB_WATCHDOG_EN;
// without it arb_timeout is tied low and DATA may last indefinitely.
module ubus_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 0,
    parameter int ID_W        = 4,
    parameter int WDOG_CYCLES = 256
) (
    input  logic              ubus_clock,
    input  logic              ubus_reset,
    ubus_arbiter_n_if.master  bus
);

    // Reject illegal configurations at elaboration time.
    if (NUM_MASTERS < 1 || NUM_MASTERS > 16) begin : g_bad_num_masters
        $error("ubus_arbiter_n: NUM_MASTERS must be 1..16");
    end
    if (ARB_MODE != 0 && ARB_MODE != 1) begin : g_bad_arb_mode
        $error("ubus_arbiter_n: ARB_MODE must be 0 or 1");
    end
    if ((2 ** ID_W) < NUM_MASTERS) begin : g_bad_id_w
        $error("ubus_arbiter_n: ID_W too narrow for NUM_MASTERS");
    end
    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_wdog
        $error("ubus_arbiter_n: WDOG_CYCLES must be 2..65535");
    end

    localparam bit RR_MODE = (ARB_MODE == 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_START,
        S_ADDR,
        S_DATA,
        S_NOOP
    } state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [ID_W-1:0]        gnt_id_q;
    logic [ID_W-1:0]        ptr_q;
    logic                   start_q;
    logic                   rw_oe_q;

    logic                   req_found_d;
    logic [ID_W-1:0]        winner_d;
    logic [NUM_MASTERS-1:0] winner_oh_d;
    logic [ID_W-1:0]        ptr_d;
    logic                   data_exit_d;

`ifdef UBUS_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
    logic [15:0] wdog_cnt_q;
    logic        timeout_q;
`endif

    // Index reached by stepping 'off' places from 'base', wrapping modulo
    // NUM_MASTERS; base is always below NUM_MASTERS, so one fold suffices.
    function automatic int wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NUM_MASTERS) ? sum - NUM_MASTERS : sum;
    endfunction

    // Winner search: first asserted request starting at index 0 (fixed)
    // or at the round-robin pointer (round-robin).
    always_comb begin
        int base;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_found_d = 1'b0;
        winner_d    = '0;
        winner_oh_d = '0;
        base        = RR_MODE ? int'(ptr_q) : 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req_found_d && bus.ubus_req[wrap_idx(base, i)]) begin
                req_found_d                      = 1'b1;
                winner_d                         = ID_W'(wrap_idx(base, i));
                winner_oh_d[wrap_idx(base, i)]   = 1'b1;
            end
        end
    end

    // Next round-robin pointer and DATA-phase exit condition.
    always_comb begin
        ptr_d       = (winner_d == ID_W'(NUM_MASTERS - 1)) ? '0 : winner_d + 1'b1;
        data_exit_d = bus.ubus_error | (~bus.ubus_bip & ~bus.ubus_wait);
    end

    // Bus-phase FSM with registered grant, grant id and phase strobes.
    always_ff @(posedge ubus_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (ubus_reset) begin
            state_q    <= S_RESET;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            start_q    <= 1'b0;
            rw_oe_q    <= 1'b0;
`ifdef UBUS_ARB_WATCHDOG_EN
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            start_q   <= 1'b0;
            rw_oe_q   <= 1'b0;
`ifdef UBUS_ARB_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                S_RESET: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                end
                S_START: begin
                    if (req_found_d) begin
                        state_q  <= S_ADDR;
                        gnt_q    <= winner_oh_d;
                        gnt_id_q <= winner_d;
                        ptr_q    <= ptr_d;
                    end else begin
                        state_q  <= S_NOOP;
                        gnt_q    <= '0;
                        rw_oe_q  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state_q    <= S_DATA;
                    gnt_q      <= '0;
`ifdef UBUS_ARB_WATCHDOG_EN
                    wdog_cnt_q <= '0;
`endif
                end
                S_DATA: begin
                    if (data_exit_d) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end
`ifdef UBUS_ARB_WATCHDOG_EN
                    else if (wdog_cnt_q == WDOG_LAST) begin
                        state_q   <= S_START;
                        start_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 16'd1;
                    end
`endif
                end
                S_NOOP: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                end
                default: begin
                    state_q <= S_RESET;
                end
            endcase
        end
    end

    assign bus.ubus_gnt    = gnt_q;
    assign bus.ubus_gnt_id = gnt_id_q;
    assign bus.ubus_start  = start_q;
    assign bus.ubus_rw_oe  = rw_oe_q;
    assign bus.ubus_read   = 1'b0;
    assign bus.ubus_write  = 1'b0;
`ifdef UBUS_ARB_WATCHDOG_EN
    assign bus.arb_timeout = timeout_q;
`else
    assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ubus_arbiter_n.sv
// tb_ubus_arbiter_n: drives a fixed-priority and a round-robin instance
// (4 masters, WDOG_CYCLES=8) with identical stimulus. Directed scenarios
// check fixed expectations; a randomized run compares every output each
// cycle against a phase-level reference model kept in this bench.
module tb_ubus_arbiter_n;

    localparam int N    = 4;
    localparam int ID_W = 4;
    localparam int WDOG = 8;

    logic ubus_clock = 1'b0;
    logic ubus_reset;
    logic [N-1:0] req;
    logic bip, wt, err;

    int checks = 0;
    int errors = 0;

    always #5 ubus_clock = ~ubus_clock;

    ubus_arbiter_n_if #(.NUM_MASTERS(N), .ID_W(ID_W)) if_fx ();
    ubus_arbiter_n_if #(.NUM_MASTERS(N), .ID_W(ID_W)) if_rr ();

    assign if_fx.ubus_req   = req;
    assign if_fx.ubus_bip   = bip;
    assign if_fx.ubus_wait  = wt;
    assign if_fx.ubus_error = err;
    assign if_rr.ubus_req   = req;
    assign if_rr.ubus_bip   = bip;
    assign if_rr.ubus_wait  = wt;
    assign if_rr.ubus_error = err;

    ubus_arbiter_n #(.NUM_MASTERS(N), .ARB_MODE(0), .ID_W(ID_W), .WDOG_CYCLES(WDOG)) dut_fx (
        .ubus_clock (ubus_clock),
        .ubus_reset (ubus_reset),
        .bus        (if_fx.master)
    );

    ubus_arbiter_n #(.NUM_MASTERS(N), .ARB_MODE(1), .ID_W(ID_W), .WDOG_CYCLES(WDOG)) dut_rr (
        .ubus_clock (ubus_clock),
        .ubus_reset (ubus_reset),
        .bus        (if_rr.master)
    );

    // ---------------- reference model ----------------
    typedef enum {PH_RST, PH_ARB, PH_ADR, PH_DAT, PH_NOP} phase_e;
    phase_e          m_ph = PH_RST;
    int              m_dlen = 0;
    int              m_ptr = 0;
    logic [N-1:0]    m_gnt_fx = '0, m_gnt_rr = '0;
    logic [ID_W-1:0] m_id_fx = '0, m_id_rr = '0;
    logic            m_to = 1'b0;

    function automatic int pick_fixed(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int pick_rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        int w_fx, w_rr;
        if (ubus_reset) begin
            m_ph = PH_RST; m_gnt_fx = '0; m_gnt_rr = '0;
            m_id_fx = '0; m_id_rr = '0; m_ptr = 0; m_to = 1'b0; m_dlen = 0;
        end else begin
            m_to = 1'b0;
            case (m_ph)
                PH_RST: m_ph = PH_ARB;
                PH_ARB: begin
                    if (req != '0) begin
                        w_fx = pick_fixed(req);
                        w_rr = pick_rr(req, m_ptr);
                        m_gnt_fx = N'(1) << w_fx;
                        m_gnt_rr = N'(1) << w_rr;
                        m_id_fx  = ID_W'(w_fx);
                        m_id_rr  = ID_W'(w_rr);
                        m_ptr    = (w_rr + 1) % N;
                        m_ph     = PH_ADR;
                    end else begin
                        m_ph = PH_NOP;
                    end
                end
                PH_ADR: begin
                    m_gnt_fx = '0; m_gnt_rr = '0; m_dlen = 1; m_ph = PH_DAT;
                end
                PH_DAT: begin
                    if (err || (!bip && !wt)) m_ph = PH_ARB;
`ifdef UBUS_ARB_WATCHDOG_EN
                    else if (m_dlen == WDOG) begin m_ph = PH_ARB; m_to = 1'b1; end
`endif
                    else m_dlen++;
                end
                PH_NOP: m_ph = PH_ARB;
                default: m_ph = PH_RST;
            endcase
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic step();
        @(posedge ubus_clock);
        model_edge();
        @(negedge ubus_clock);
    endtask

    task automatic do_reset(input int n);
        ubus_reset = 1'b1; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;
        repeat (n) step();
        ubus_reset = 1'b0;
    endtask

    // Collect the first n round-robin grants (ids and one-hot vectors).
    task automatic collect_rr(input logic [N-1:0] pat, input int n,
                              output int ids[$], output int gnts[$]);
        ids.delete(); gnts.delete();
        do_reset(2);
        req = pat;
        for (int c = 0; c < 60 && ids.size() < n; c++) begin
            step();
            if (if_rr.ubus_gnt != '0) begin
                ids.push_back(int'(if_rr.ubus_gnt_id));
                gnts.push_back(int'(if_rr.ubus_gnt));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ubus_reset = 1'b1; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({if_fx.ubus_start, if_fx.ubus_rw_oe, if_fx.ubus_gnt, if_fx.ubus_gnt_id, if_fx.arb_timeout,
                 if_rr.ubus_start, if_rr.ubus_rw_oe, if_rr.ubus_gnt, if_rr.ubus_gnt_id, if_rr.arb_timeout} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: fx start=%b oe=%b gnt=%b id=%0d rr start=%b gnt=%b, expected all 0",
                         c, if_fx.ubus_start, if_fx.ubus_rw_oe, if_fx.ubus_gnt, if_fx.ubus_gnt_id,
                         if_rr.ubus_start, if_rr.ubus_gnt);
            end
        end
        ubus_reset = 1'b0;
        step();
        checks++;
        if (if_fx.ubus_start !== 1'b1 || if_rr.ubus_start !== 1'b1 || if_fx.ubus_rw_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_start: start fx=%b rr=%b oe=%b, expected start=1 oe=0",
                     if_fx.ubus_start, if_rr.ubus_start, if_fx.ubus_rw_oe);
        end
        for (int c = 0; c < 6; c++) begin
            logic exp_start;
            step();
            exp_start = (c % 2 == 1);
            checks++;
            if (if_fx.ubus_start !== exp_start || if_fx.ubus_rw_oe !== !exp_start ||
                if_rr.ubus_start !== exp_start || if_rr.ubus_rw_oe !== !exp_start ||
                if_fx.ubus_gnt !== '0 || if_rr.ubus_gnt !== '0) begin
                errors++;
                $display("FAIL idle_alternation cycle %0d: start=%b oe=%b gnt=%b, expected start=%b oe=%b gnt=0",
                         c, if_fx.ubus_start, if_fx.ubus_rw_oe, if_fx.ubus_gnt, exp_start, !exp_start);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic prev_start = 1'b0;
        logic seen3 = 1'b0;
        int grants = 0;
        do_reset(2);
        req = 4'b1010;
        for (int c = 0; c < 30; c++) begin
            step();
            if (prev_start) begin
                grants++;
                checks++;
                if (if_fx.ubus_gnt !== 4'b0010 || if_fx.ubus_gnt_id !== 4'd1) begin
                    errors++;
                    $display("FAIL fixed_grant cycle %0d: gnt=%b id=%0d, expected gnt=0010 id=1",
                             c, if_fx.ubus_gnt, if_fx.ubus_gnt_id);
                end
            end
            if (if_fx.ubus_gnt[3] === 1'b1) seen3 = 1'b1;
            prev_start = if_fx.ubus_start;
        end
        checks++;
        if (grants < 5 || seen3) begin
            errors++;
            $display("FAIL fixed_count: grants=%0d master3_granted=%b, expected >=5 and 0", grants, seen3);
        end
    endtask

    task automatic test_round_robin();
        int ids[$], gnts[$];
        int exp_a[5] = '{0, 1, 2, 3, 0};
        int exp_b[4] = '{0, 3, 0, 3};
        collect_rr(4'b1111, 5, ids, gnts);
        checks++;
        if (ids.size() != 5) begin
            errors++;
            $display("FAIL rr_1111_count: got %0d grants, expected 5", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            checks++;
            if (ids[i] != exp_a[i] || gnts[i] != (1 << exp_a[i])) begin
                errors++;
                $display("FAIL rr_1111_order #%0d: id=%0d gnt=%0h, expected id=%0d gnt=%0h",
                         i, ids[i], gnts[i], exp_a[i], 1 << exp_a[i]);
            end
        end
        collect_rr(4'b1001, 4, ids, gnts);
        checks++;
        if (ids.size() != 4) begin
            errors++;
            $display("FAIL rr_1001_count: got %0d grants, expected 4", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            checks++;
            if (ids[i] != exp_b[i] || gnts[i] != (1 << exp_b[i])) begin
                errors++;
                $display("FAIL rr_1001_order #%0d: id=%0d gnt=%0h, expected id=%0d gnt=%0h",
                         i, ids[i], gnts[i], exp_b[i], 1 << exp_b[i]);
            end
        end
    endtask

    task automatic test_data_exit();
        int k;
        do_reset(2);
        req = 4'b0001;
        for (int c = 0; c < 10 && if_fx.ubus_gnt == '0; c++) step();
        checks++;
        if (if_fx.ubus_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL data_grant: gnt=%b, expected 0001", if_fx.ubus_gnt);
        end
        req = '0;          // grantee drops its request; transfer continues
        bip = 1'b1; wt = 1'b0;
        step();            // now in DATA cycle 1
        k = 1;
        while (if_fx.ubus_start == 1'b0 && k < 20) begin
            if (k <= 3)      begin bip = 1'b1; wt = 1'b0; end
            else if (k <= 5) begin bip = 1'b0; wt = 1'b1; end
            else             begin bip = 1'b0; wt = 1'b0; end
            step();
            if (if_fx.ubus_start == 1'b0) k++;
        end
        checks++;
        if (k != 6 || if_fx.ubus_start !== 1'b1 || if_fx.arb_timeout !== 1'b0 || if_fx.ubus_gnt_id !== 4'd0) begin
            errors++;
            $display("FAIL data_length: cycles=%0d start=%b timeout=%b id=%0d, expected 6, 1, 0, 0",
                     k, if_fx.ubus_start, if_fx.arb_timeout, if_fx.ubus_gnt_id);
        end
        req = 4'b0001;
        step();            // ADDR
        bip = 1'b1; wt = 1'b1; err = 1'b0;
        step();            // DATA cycle 1
        checks++;
        if (if_fx.ubus_start !== 1'b0 || if_fx.ubus_gnt !== '0) begin
            errors++;
            $display("FAIL error_setup: start=%b gnt=%b, expected 0 and 0", if_fx.ubus_start, if_fx.ubus_gnt);
        end
        err = 1'b1;
        step();
        checks++;
        if (if_fx.ubus_start !== 1'b1 || if_fx.arb_timeout !== 1'b0) begin
            errors++;
            $display("FAIL error_exit: start=%b timeout=%b, expected 1 and 0", if_fx.ubus_start, if_fx.arb_timeout);
        end
        err = 1'b0; bip = 1'b0; wt = 1'b0; req = '0;
    endtask

    task automatic test_reset_mid_data();
        do_reset(2);
        req = 4'b1111; bip = 1'b1;
        for (int c = 0; c < 10 && if_rr.ubus_gnt == '0; c++) step();
        checks++;
        if (if_rr.ubus_gnt_id !== 4'd0 || if_rr.ubus_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_first_grant: id=%0d gnt=%b, expected 0 and 0001", if_rr.ubus_gnt_id, if_rr.ubus_gnt);
        end
        step();            // DATA cycle 1
        step();            // DATA cycle 2
        checks++;
        if (if_rr.ubus_start !== 1'b0 || if_rr.ubus_rw_oe !== 1'b0 || if_rr.ubus_gnt !== '0) begin
            errors++;
            $display("FAIL midreset_in_data: start=%b oe=%b gnt=%b, expected all 0",
                     if_rr.ubus_start, if_rr.ubus_rw_oe, if_rr.ubus_gnt);
        end
        ubus_reset = 1'b1;
        step();
        checks++;
        if ({if_rr.ubus_start, if_rr.ubus_rw_oe, if_rr.ubus_gnt, if_rr.ubus_gnt_id, if_rr.arb_timeout,
             if_fx.ubus_start, if_fx.ubus_gnt, if_fx.ubus_gnt_id} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rr start=%b oe=%b gnt=%b id=%0d fx id=%0d, expected all 0",
                     if_rr.ubus_start, if_rr.ubus_rw_oe, if_rr.ubus_gnt, if_rr.ubus_gnt_id, if_fx.ubus_gnt_id);
        end
        ubus_reset = 1'b0; bip = 1'b0;
        step();            // START
        step();            // ADDR
        checks++;
        if (if_rr.ubus_gnt !== 4'b0001 || if_rr.ubus_gnt_id !== 4'd0) begin
            errors++;
            $display("FAIL midreset_ptr_cleared: gnt=%b id=%0d, expected 0001 and 0", if_rr.ubus_gnt, if_rr.ubus_gnt_id);
        end
        req = '0;
    endtask

    task automatic test_watchdog();
        int k;
        logic early_to = 1'b0;
        do_reset(2);
        req = 4'b0001;
        for (int c = 0; c < 10 && if_fx.ubus_gnt == '0; c++) step();
        req = '0; bip = 1'b1; wt = 1'b0;
        step();            // DATA cycle 1
        k = 1;
        while (if_fx.ubus_start == 1'b0 && k < 20) begin
            if (if_fx.arb_timeout !== 1'b0 || if_rr.arb_timeout !== 1'b0) early_to = 1'b1;
            step();
            if (if_fx.ubus_start == 1'b0) k++;
        end
`ifdef UBUS_ARB_WATCHDOG_EN
        checks++;
        if (k != WDOG || if_fx.ubus_start !== 1'b1 || if_fx.arb_timeout !== 1'b1 ||
            if_rr.arb_timeout !== 1'b1 || early_to) begin
            errors++;
            $display("FAIL wdog_fire: data_cycles=%0d start=%b timeout fx=%b rr=%b early=%b, expected %0d,1,1,1,0",
                     k, if_fx.ubus_start, if_fx.arb_timeout, if_rr.arb_timeout, early_to, WDOG);
        end
        step();
        checks++;
        if (if_fx.arb_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_pulse_width: timeout=%b one cycle later, expected 0", if_fx.arb_timeout);
        end
`else
        checks++;
        if (k != 20 || if_fx.ubus_start !== 1'b0 || if_fx.arb_timeout !== 1'b0 || early_to) begin
            errors++;
            $display("FAIL wdog_absent: data_cycles=%0d start=%b timeout=%b early=%b, expected 20,0,0,0",
                     k, if_fx.ubus_start, if_fx.arb_timeout, early_to);
        end
`endif
        bip = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [20:0] act, exp;
        for (int c = 0; c < 800; c++) begin
            ubus_reset = ($urandom_range(0, 79) == 0);
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            bip = ($urandom_range(0, 99) < 75);
            wt  = ($urandom_range(0, 99) < 40);
            err = ($urandom_range(0, 99) < 5);
            step();
            act = {if_fx.ubus_start, if_fx.ubus_rw_oe, if_fx.arb_timeout, if_fx.ubus_read, if_fx.ubus_write,
                   if_fx.ubus_gnt, if_fx.ubus_gnt_id, if_rr.ubus_gnt, if_rr.ubus_gnt_id};
            exp = {m_ph == PH_ARB, m_ph == PH_NOP, m_to, 1'b0, 1'b0, m_gnt_fx, m_id_fx, m_gnt_rr, m_id_rr};
            checks++;
            if (act !== exp || if_rr.ubus_start !== (m_ph == PH_ARB) || if_rr.arb_timeout !== m_to) begin
                errors++;
                $display("FAIL random cycle %0d: {start,oe,to,rd,wr,gnt_fx,id_fx,gnt_rr,id_rr}=%h, expected %h",
                         c, act, exp);
            end
        end
        ubus_reset = 1'b0;
    endtask

    initial begin
        ubus_reset = 1'b1; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_data_exit();
        test_reset_mid_data();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
